// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for inter-stage pipeline buffers: buffer state encoding and
// the payload packing used by stages that drive in_data.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_buf_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
    } rv32i_control_word_t;

    // Stages pack the control word in the MSBs, followed by the datapath fields.
    typedef struct packed {
        rv32i_control_word_t ctrl;
        logic [31:0]         pc;
        logic [31:0]         rs1_val;
        logic [31:0]         rs2_val;
        logic [31:0]         imm;
        logic [4:0]          rd;
    } stage_payload_t;

    localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

    function automatic logic [1:0] occupancy_of(pipe_buf_state_t s);
        case (s)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with optional 2-entry skid buffer, synchronous
// flush and a saturating stall counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SKID_EN     = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_buf_state_t  state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // With the skid buffer, in_ready depends only on registered state.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = (state_q != SKID);
        end else begin
            in_ready = (state_q == EMPTY) || out_ready;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occupancy_of(state_q);
    assign stall_cnt = cnt_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && (SKID_EN != 0)) begin
                    skid_d  = in_data;
                    state_d = SKID;
                end
            end
            SKID: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops every entry but leaves the payload registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_stats) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
